// File: rtl/proc_vec_pkg.sv
// Shared default sizing for the processor vector register bank.
package proc_vec_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned NUM_REGS_DEF = 8;
  localparam int unsigned NUM_TAPS_DEF = 4;

endpackage

// File: rtl/banco_reg_esc_p_marcador_pend.sv
// Pending-bit scoreboard and read-stall generation for banco_reg_esc_p.
// BANCO_REG_BYPASS_EN: a pending bit cleared by a same-cycle write does not stall.
module marcador_pend
  import proc_vec_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [NUM_REGS-1:0] pend,
  output logic                stall
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                pend_a, pend_b;

  // Out-of-range addresses never match an index, so they read as not pending.
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef BANCO_REG_BYPASS_EN
      if (rd_addr_a == ADDR_W'(i))
        pend_a = pend_q[i] & ~(wr_en && (wr_addr == ADDR_W'(i)));
      if (rd_addr_b == ADDR_W'(i))
        pend_b = pend_q[i] & ~(wr_en && (wr_addr == ADDR_W'(i)));
`else
      if (rd_addr_a == ADDR_W'(i)) pend_a = pend_q[i];
      if (rd_addr_b == ADDR_W'(i)) pend_b = pend_q[i];
`endif
    end
    stall = rd_en & (pend_a | pend_b);
  end

  // Write-back clears, issue sets; issue is applied last so it wins on a collision.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i)))   pend_d[i] = 1'b0;
      if (iss_en && (iss_addr == ADDR_W'(i))) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend = pend_q;

endmodule

// File: rtl/banco_reg_esc_p.sv
// Two-read/one-write register bank with pending-bit scoreboard and debug taps.
// BANCO_REG_BYPASS_EN: forward write data to a same-cycle read of the same address.
module banco_reg_esc_p
  import proc_vec_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_TAPS = NUM_TAPS_DEF,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr_a,
  input  logic [ADDR_W-1:0]          rd_addr_b,
  output logic [DATA_W-1:0]          rd_data_a,
  output logic [DATA_W-1:0]          rd_data_b,
  output logic                       rd_valid,
  output logic                       stall,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [NUM_REGS-1:0]        pend,
  output logic [NUM_TAPS*DATA_W-1:0] taps
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] reg_val_a, reg_val_b;
  logic [DATA_W-1:0] fwd_a, fwd_b;
`ifdef BANCO_REG_BYPASS_EN
  logic              wr_in_range;
`endif

  marcador_pend #(
    .NUM_REGS (NUM_REGS)
  ) u_marcador_pend (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .pend      (pend),
    .stall     (stall)
  );

  // Read mux: out-of-range addresses match no register and read as zero.
  always_comb begin
    reg_val_a = '0;
    reg_val_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) reg_val_a = regs_q[i];
      if (rd_addr_b == ADDR_W'(i)) reg_val_b = regs_q[i];
    end
    fwd_a = reg_val_a;
    fwd_b = reg_val_b;
`ifdef BANCO_REG_BYPASS_EN
    wr_in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_in_range = 1'b1;
    end
    if (wr_en && wr_in_range && (wr_addr == rd_addr_a)) fwd_a = wr_data;
    if (wr_en && wr_in_range && (wr_addr == rd_addr_b)) fwd_b = wr_data;
`endif
  end

  always_comb begin
    regs_d      = regs_q;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_valid_d  = 1'b0;
    if (rd_en && !stall) begin
      rd_data_a_d = fwd_a;
      rd_data_b_d = fwd_b;
      rd_valid_d  = 1'b1;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;

  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_taps
    assign taps[t*DATA_W +: DATA_W] = regs_q[t];
  end

endmodule

// File: tb/tb_banco_reg_esc_p.sv
// Self-checking bench for banco_reg_esc_p: directed scenarios plus random traffic vs a model.
module tb_banco_reg_esc_p;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en, iss_en;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, iss_addr;
  logic [7:0]  wr_data, rd_data_a, rd_data_b;
  logic        rd_valid, stall;
  logic [7:0]  pend;
  logic [31:0] taps;

  logic        rst6, rd_en6, wr_en6, iss_en6;
  logic [2:0]  rd_addr_a6, rd_addr_b6, wr_addr6, iss_addr6;
  logic [7:0]  wr_data6, rd_data_a6, rd_data_b6;
  logic        rd_valid6, stall6;
  logic [5:0]  pend6;
  logic [31:0] taps6;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_regs [8];
  logic [7:0] m_pend;
  logic [7:0] m_rd_a, m_rd_b;
  logic       m_valid;

  always #5 clk = ~clk;

  banco_reg_esc_p dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid), .stall(stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend(pend), .taps(taps)
  );

  banco_reg_esc_p #(.NUM_REGS(6)) dut6 (
    .clk(clk), .rst(rst6), .rd_en(rd_en6), .rd_addr_a(rd_addr_a6), .rd_addr_b(rd_addr_b6),
    .rd_data_a(rd_data_a6), .rd_data_b(rd_data_b6), .rd_valid(rd_valid6), .stall(stall6),
    .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6), .iss_en(iss_en6), .iss_addr(iss_addr6),
    .pend(pend6), .taps(taps6)
  );

  task automatic drive(input logic r, input logic re, input logic [2:0] a, input logic [2:0] b,
                       input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic ie, input logic [2:0] ia);
    rst = r; rd_en = re; rd_addr_a = a; rd_addr_b = b;
    wr_en = we; wr_addr = wa; wr_data = wd; iss_en = ie; iss_addr = ia;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
  endtask

  function automatic logic exp_stall();
    logic pa, pb;
    pa = m_pend[rd_addr_a];
    pb = m_pend[rd_addr_b];
`ifdef BANCO_REG_BYPASS_EN
    if (wr_en && wr_addr == rd_addr_a) pa = 1'b0;
    if (wr_en && wr_addr == rd_addr_b) pb = 1'b0;
`endif
    return rd_en && (pa || pb);
  endfunction

  function automatic logic [31:0] exp_taps();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  // Advance one clock edge and apply the register-bank rules to the model.
  task automatic tick();
    logic       st;
    logic [7:0] va, vb;
    st = exp_stall();
    va = m_regs[rd_addr_a];
    vb = m_regs[rd_addr_b];
`ifdef BANCO_REG_BYPASS_EN
    if (wr_en && wr_addr == rd_addr_a) va = wr_data;
    if (wr_en && wr_addr == rd_addr_b) vb = wr_data;
`endif
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_pend = 8'h00; m_rd_a = 8'h00; m_rd_b = 8'h00; m_valid = 1'b0;
    end else begin
      m_valid = rd_en && !st;
      if (m_valid) begin m_rd_a = va; m_rd_b = vb; end
      if (wr_en) begin m_regs[wr_addr] = wr_data; m_pend[wr_addr] = 1'b0; end
      if (iss_en) m_pend[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 8'h77, 1'b1, 3'd6);
    tick();
    drive(1'b1, 1'b1, 3'd0, 3'd2, 1'b1, 3'd2, 8'h55, 1'b1, 3'd3);
    tick();
    idle();
    checks++; if (taps !== 32'h0) begin errors++; $display("FAIL reset_taps: got %h expected %h", taps, 32'h0); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h expected %h", pend, 8'h00); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected 00/00", rd_data_a, rd_data_b); end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0);
    tick();
    drive(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wr_rd_stall: got %b expected 0", stall); end
    tick();
    idle();
    checks++; if (rd_data_a !== 8'hA5) begin errors++; $display("FAIL wr_rd_a: got %h expected a5", rd_data_a); end
    checks++; if (rd_data_b !== 8'h00) begin errors++; $display("FAIL wr_rd_b: got %h expected 00", rd_data_b); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b expected 1", rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data_a !== 8'hA5) begin
      errors++; $display("FAIL wr_rd_hold: got valid=%b a=%h expected valid=0 a=a5", rd_valid, rd_data_a); end
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5);
    tick();
    checks++; if (pend[5] !== 1'b1) begin errors++; $display("FAIL sb_pend_set: got %b expected 1", pend[5]); end
    drive(1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall: got %b expected 1", stall); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL sb_no_valid: got %b expected 0", rd_valid); end
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 8'h3C, 1'b0, 3'd0);
    tick();
    checks++; if (pend[5] !== 1'b0) begin errors++; $display("FAIL sb_pend_clr: got %b expected 0", pend[5]); end
    drive(1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_unstall: got %b expected 0", stall); end
    tick();
    idle();
    checks++; if (rd_data_a !== 8'h3C || rd_valid !== 1'b1) begin
      errors++; $display("FAIL sb_read: got a=%h valid=%b expected a=3c valid=1", rd_data_a, rd_valid); end
  endtask

  task automatic test_simultaneous();
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 8'h9E, 1'b1, 3'd1);
    tick();
    idle();
    checks++; if (pend[1] !== 1'b1) begin errors++; $display("FAIL simul_pend: got %b expected 1", pend[1]); end
    checks++; if (taps[15:8] !== 8'h9E) begin errors++; $display("FAIL simul_data: got %h expected 9e", taps[15:8]); end
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 8'h9E, 1'b0, 3'd0);
    tick();
    idle();
    checks++; if (pend[1] !== 1'b0) begin errors++; $display("FAIL simul_clear: got %b expected 0", pend[1]); end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_v;
    logic       exp_s;
`ifdef BANCO_REG_BYPASS_EN
    exp_v = 8'h22; exp_s = 1'b0;
`else
    exp_v = 8'h11; exp_s = 1'b1;
`endif
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd4, 8'h11, 1'b0, 3'd0);
    tick();
    drive(1'b0, 1'b1, 3'd4, 3'd4, 1'b1, 3'd4, 8'h22, 1'b0, 3'd0);
    tick();
    idle();
    checks++; if (rd_data_a !== exp_v || rd_data_b !== exp_v) begin
      errors++; $display("FAIL bypass_data: got %h/%h expected %h", rd_data_a, rd_data_b, exp_v); end
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6);
    tick();
    drive(1'b0, 1'b1, 3'd6, 3'd0, 1'b1, 3'd6, 8'h66, 1'b0, 3'd0);
    #1;
    checks++; if (stall !== exp_s) begin errors++; $display("FAIL bypass_stall: got %b expected %b", stall, exp_s); end
    tick();
    idle();
    checks++; if (rd_valid !== !exp_s) begin errors++; $display("FAIL bypass_valid: got %b expected %b", rd_valid, !exp_s); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 6),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 8'($urandom),
            ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      #1;
      checks++; if (stall !== exp_stall()) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, stall, exp_stall()); end
      tick();
      checks++; if (rd_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, rd_valid, m_valid); end
      checks++; if (rd_data_a !== m_rd_a || rd_data_b !== m_rd_b) begin
        errors++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h/%h", n, rd_data_a, rd_data_b, m_rd_a, m_rd_b); end
      checks++; if (pend !== m_pend) begin
        errors++; $display("FAIL rnd_pend[%0d]: got %h expected %h", n, pend, m_pend); end
      checks++; if (taps !== exp_taps()) begin
        errors++; $display("FAIL rnd_taps[%0d]: got %h expected %h", n, taps, exp_taps()); end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    idle();
    rst6 = 1'b1; tick(); rst6 = 1'b0;
    wr_en6 = 1'b1; wr_addr6 = 3'd7; wr_data6 = 8'hEE; iss_en6 = 1'b1; iss_addr6 = 3'd7;
    tick();
    wr_en6 = 1'b0; iss_en6 = 1'b0;
    checks++; if (pend6 !== 6'h00) begin errors++; $display("FAIL oor_pend: got %h expected 00", pend6); end
    checks++; if (taps6 !== 32'h0) begin errors++; $display("FAIL oor_taps: got %h expected 0", taps6); end
    wr_en6 = 1'b1; wr_addr6 = 3'd5; wr_data6 = 8'h5A;
    tick();
    wr_en6 = 1'b0;
    rd_en6 = 1'b1; rd_addr_a6 = 3'd7; rd_addr_b6 = 3'd5;
    #1;
    checks++; if (stall6 !== 1'b0) begin errors++; $display("FAIL oor_stall: got %b expected 0", stall6); end
    tick();
    rd_en6 = 1'b0;
    checks++; if (rd_data_a6 !== 8'h00 || rd_data_b6 !== 8'h5A || rd_valid6 !== 1'b1) begin
      errors++; $display("FAIL oor_read: got a=%h b=%h v=%b expected a=00 b=5a v=1", rd_data_a6, rd_data_b6, rd_valid6); end
    rd_en6 = 1'b1; rd_addr_a6 = 3'd6; rd_addr_b6 = 3'd7;
    tick();
    rd_en6 = 1'b0;
    checks++; if (rd_data_a6 !== 8'h00 || rd_data_b6 !== 8'h00) begin
      errors++; $display("FAIL oor_read6: got %h/%h expected 00/00", rd_data_a6, rd_data_b6); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_pend = 8'h00; m_rd_a = 8'h00; m_rd_b = 8'h00; m_valid = 1'b0;
    rst6 = 1'b1; rd_en6 = 1'b0; rd_addr_a6 = 3'd0; rd_addr_b6 = 3'd0;
    wr_en6 = 1'b0; wr_addr6 = 3'd0; wr_data6 = 8'h00; iss_en6 = 1'b0; iss_addr6 = 3'd0;
    drive(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    @(negedge clk);
    tick();
    tick();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_random();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
